ysyx_22041412_icache: RTL and testbench
=======================================

// Module: ysyx_22041412_icache
// PURPOSE
//  Instruction cache; the responder end of the IFU fetch interface.
//  Serves 128-bit aligned instruction lines to the IFU.
//  Handles request abort (IFU clean) and fence.i invalidate.
//  Refills misses from the memory side in two 64-bit beats.
//  Direct-mapped. Valid/tag/data arrays are held in flops.
// PARAMETERS
//  SET_BITS  6  log2(number of lines); 2^SET_BITS lines of 16 B each
//  ADDR_W   32  address width; tag = addr[ADDR_W-1:4+SET_BITS], set = addr[4+SET_BITS-1:4]
// PORTS
//  clk           in   1    clock
//  rst           in   1    synchronous, active-high reset
//  req_valid_i   in   1    IFU fetch request; held high until the response is taken
//  req_addr_i    in   32   fetch address; bits [3:0] ignored
//  resp_ready_o  out  1    resp_data_o valid; held until req_valid_i falls
//  resp_data_o   out  128  line data; word n = [32n+31:32n]
//  abort_i       in   1    IFU clean: cancel outstanding request
//  abort_done_o  out  1    cache idle; abort complete
//  fence_i_i     in   1    invalidate all lines (level)
//  fence_done_o  out  1    one-cycle pulse when invalidate is finished
//  mem_valid_o   out  1    refill request
//  mem_addr_o    out  32   refill address, line aligned ({tag,set,4'b0})
//  mem_ready_i   in   1    memory accepts the request (handshake on valid&ready)
//  mem_rvalid_i  in   1    read beat valid; beat0=[63:0], beat1=[127:64]
//  mem_rdata_i   in   64   read beat data
// BEHAVIOUR
//  States: INIT, IDLE, LOOKUP, MISS_REQ, REFILL, RESP, DRAIN, FENCE.
//  Reset: state=INIT; sweep counter=0; all valid bits=0.
//   Reset values of outputs: resp_ready_o=0, resp_data_o=0, abort_done_o=0,
//   fence_done_o=0, mem_valid_o=0, mem_addr_o=0.
//   Reset mid-operation discards any refill in flight.
//  INIT / FENCE: sweep counter clears one set's valid bit per cycle for 2^SET_BITS cycles.
//   INIT then goes to IDLE.
//   FENCE then goes to IDLE and pulses fence_done_o for 1 cycle.
//   Both states ignore requests and abort_i.
//  abort_done_o: registered; 1 exactly in the cycles where state==IDLE.
//  IDLE priority: abort_i > fence_i_i > req_valid_i.
//   abort_i=1: stay in IDLE.
//   fence_i_i=1: go to FENCE.
//   req_valid_i=1: latch the address, go to LOOKUP.
//  LOOKUP: hit = valid[set] && tag match.
//   Hit: load resp_data_o, go to RESP.
//   Miss: go to MISS_REQ.
//   abort_i=1: go to IDLE.
//  Hit latency: request seen in IDLE at cycle T -> resp_ready_o=1 at T+2.
//  MISS_REQ: mem_valid_o=1; mem_addr_o stable until mem_ready_i.
//   No withdrawal once asserted.
//   On handshake: refill beat counter=0, go to REFILL (or DRAIN if abort seen).
//  REFILL: each mem_rvalid_i stores one beat; mem_rvalid_i in other states is ignored.
//   On beat1: write data, tag and valid=1, load resp_data_o, go to RESP.
//  RESP: resp_ready_o=1, resp_data_o stable.
//   req_valid_i=0 or abort_i=1: resp_ready_o=0 next cycle, go to IDLE.
//  Abort during MISS_REQ or REFILL: go to DRAIN.
//   DRAIN finishes the handshake and both beats.
//   The line is still written into the array; no response is given.
//   Then go to IDLE (abort_done_o=1).
//  Abort in the same cycle as the beat1 write: line written, no RESP, go to IDLE.
//  fence_i_i while busy: held as a level and serviced on return to IDLE.
// TESTING
//  1. Reset, then req 0x80000000 -> abort_done_o=0 for 64 cycles, then 1.
//     Miss gives mem_addr_o=0x80000000.
//     Beats 0x1111111122222222, 0x3333333344444444 -> resp_data_o=0x33333333444444441111111122222222.
//  2. Req 0x80000008 after test 1 -> hit; resp_ready_o=1 two cycles after the request; mem_valid_o stays 0.
//  3. Req 0x80000400 (same set, new tag) -> miss, refill, replace.
//     Then req 0x80000000 -> miss again.
//  4. abort_i after beat0 of a refill -> resp_ready_o never rises.
//     abort_done_o=0 until beat1, then 1.
//     A later request to that line hits.
//  5. fence_i_i in IDLE -> fence_done_o pulses exactly once, 64 cycles later.
//     Next req 0x80000000 misses.
//  6. mem_ready_i low for 5 cycles -> mem_valid_o=1 and mem_addr_o constant throughout.
//     Exactly one handshake occurs.

Source files
------------

// File: rtl/ysyx_22041412_icache.sv
// Direct-mapped instruction cache serving 128-bit lines to the IFU.
// Misses refill in two 64-bit beats; abort and fence.i invalidate are supported.
module ysyx_22041412_icache #(
    parameter int SET_BITS = 6,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    output logic              resp_ready_o,
    output logic [127:0]      resp_data_o,
    input  logic              abort_i,
    output logic              abort_done_o,
    input  logic              fence_i_i,
    output logic              fence_done_o,
    output logic              mem_valid_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ready_i,
    input  logic              mem_rvalid_i,
    input  logic [63:0]       mem_rdata_i
);
    localparam int SETS  = 1 << SET_BITS;
    localparam int TAG_W = ADDR_W - 4 - SET_BITS;

    typedef enum logic [2:0] {
        INIT, IDLE, LOOKUP, MISS_REQ, REFILL, RESP, DRAIN, FENCE
    } state_t;

    state_t              state;
    logic [SETS-1:0]     valid;
    logic [TAG_W-1:0]    tags  [SETS];
    logic [127:0]        lines [SETS];
    logic [SET_BITS-1:0] sweep;
    logic [ADDR_W-5:0]   addr;
    logic                beat;
    logic                req_done;
    logic [63:0]         beat0;
    logic [SET_BITS-1:0] idx;
    logic [TAG_W-1:0]    tag;
    logic                hit;
    logic                fill_we;
    logic [127:0]        fill_line;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^req_addr_i[3:0];
    assign idx       = addr[SET_BITS-1:0];
    assign tag       = addr[ADDR_W-5:SET_BITS];
    assign hit       = valid[idx] && (tags[idx] == tag);
    assign fill_line = {mem_rdata_i, beat0};
    // The second beat completes a line both on a normal refill and while draining after an abort.
    assign fill_we   = !rst && mem_rvalid_i && beat &&
                       (state == REFILL || (state == DRAIN && req_done));

    always_ff @(posedge clk) begin
        if (mem_rvalid_i && !beat)
            beat0 <= mem_rdata_i;
        if (fill_we) begin
            tags[idx]  <= tag;
            lines[idx] <= fill_line;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= INIT;
            sweep        <= '0;
            valid        <= '0;
            addr         <= '0;
            beat         <= 1'b0;
            req_done     <= 1'b0;
            resp_ready_o <= 1'b0;
            resp_data_o  <= '0;
            abort_done_o <= 1'b0;
            fence_done_o <= 1'b0;
            mem_valid_o  <= 1'b0;
            mem_addr_o   <= '0;
        end else begin
            // abort_done_o tracks "next state is IDLE" so it is high exactly while in IDLE.
            abort_done_o <= 1'b0;
            fence_done_o <= 1'b0;
            if (fill_we)
                valid[idx] <= 1'b1;
            case (state)
                INIT, FENCE: begin
                    valid[sweep] <= 1'b0;
                    sweep        <= sweep + 1'b1;
                    if (&sweep) begin
                        state        <= IDLE;
                        abort_done_o <= 1'b1;
                        fence_done_o <= (state == FENCE);
                    end
                end
                IDLE: begin
                    if (abort_i) begin
                        abort_done_o <= 1'b1;
                    end else if (fence_i_i) begin
                        sweep <= '0;
                        state <= FENCE;
                    end else if (req_valid_i) begin
                        addr  <= req_addr_i[ADDR_W-1:4];
                        state <= LOOKUP;
                    end else begin
                        abort_done_o <= 1'b1;
                    end
                end
                LOOKUP: begin
                    if (abort_i) begin
                        state        <= IDLE;
                        abort_done_o <= 1'b1;
                    end else if (hit) begin
                        resp_data_o  <= lines[idx];
                        resp_ready_o <= 1'b1;
                        state        <= RESP;
                    end else begin
                        mem_valid_o <= 1'b1;
                        mem_addr_o  <= {addr, 4'b0};
                        state       <= MISS_REQ;
                    end
                end
                MISS_REQ: begin
                    if (mem_ready_i) begin
                        mem_valid_o <= 1'b0;
                        beat        <= 1'b0;
                        req_done    <= 1'b1;
                        state       <= abort_i ? DRAIN : REFILL;
                    end else if (abort_i) begin
                        req_done <= 1'b0;
                        state    <= DRAIN;
                    end
                end
                REFILL: begin
                    if (mem_rvalid_i && beat) begin
                        if (abort_i) begin
                            state        <= IDLE;
                            abort_done_o <= 1'b1;
                        end else begin
                            resp_data_o  <= fill_line;
                            resp_ready_o <= 1'b1;
                            state        <= RESP;
                        end
                    end else begin
                        if (mem_rvalid_i)
                            beat <= 1'b1;
                        if (abort_i)
                            state <= DRAIN;
                    end
                end
                RESP: begin
                    if (!req_valid_i || abort_i) begin
                        resp_ready_o <= 1'b0;
                        state        <= IDLE;
                        abort_done_o <= 1'b1;
                    end
                end
                DRAIN: begin
                    // Finish the outstanding handshake first, then swallow both beats.
                    if (!req_done) begin
                        if (mem_ready_i) begin
                            mem_valid_o <= 1'b0;
                            req_done    <= 1'b1;
                            beat        <= 1'b0;
                        end
                    end else if (mem_rvalid_i) begin
                        if (beat) begin
                            state        <= IDLE;
                            abort_done_o <= 1'b1;
                        end else begin
                            beat <= 1'b1;
                        end
                    end
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_22041412_icache.sv
// Self-checking bench for ysyx_22041412_icache against a set/tag reference model
// and a lazily-filled random backing memory.
module tb_ysyx_22041412_icache;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic [31:0]  req_addr = '0;
    logic         resp_ready;
    logic [127:0] resp_data;
    logic         abort = 1'b0;
    logic         abort_done;
    logic         fence = 1'b0;
    logic         fence_done;
    logic         mem_valid;
    logic [31:0]  mem_addr;
    logic         mem_ready = 1'b0;
    logic         mem_rvalid = 1'b0;
    logic [63:0]  mem_rdata = '0;

    int tests = 0;
    int fails = 0;

    bit           mvalid [64];
    logic [21:0]  mtag   [64];
    logic [127:0] mem    [logic [27:0]];

    localparam logic [127:0] LINE0 = 128'h33333333444444441111111122222222;

    always #5 clk = ~clk;

    ysyx_22041412_icache dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_addr_i   (req_addr),
        .resp_ready_o (resp_ready),
        .resp_data_o  (resp_data),
        .abort_i      (abort),
        .abort_done_o (abort_done),
        .fence_i_i    (fence),
        .fence_done_o (fence_done),
        .mem_valid_o  (mem_valid),
        .mem_addr_o   (mem_addr),
        .mem_ready_i  (mem_ready),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] mem_line(logic [31:0] a);
        if (!mem.exists(a[31:4]))
            mem[a[31:4]] = {$urandom, $urandom, $urandom, $urandom};
        return mem[a[31:4]];
    endfunction

    function automatic bit model_hit(logic [31:0] a);
        return mvalid[a[9:4]] && (mtag[a[9:4]] == a[31:10]);
    endfunction

    function automatic void model_fill(logic [31:0] a);
        mvalid[a[9:4]] = 1'b1;
        mtag[a[9:4]]   = a[31:10];
    endfunction

    function automatic void model_flush();
        foreach (mvalid[i]) mvalid[i] = 1'b0;
    endfunction

    // Drives one fetch acting as IFU and memory; reports what was observed.
    task automatic fetch(input logic [31:0] a, input int delay,
                         output logic [127:0] data, output bit missed, output int lat,
                         output logic [31:0] maddr, output bit stable, output int hs_cnt,
                         output int vcyc, output bit timeout, output logic after);
        logic [127:0] line;
        bit hs;
        int phase;
        data = '0; missed = 0; lat = 0; maddr = '0; stable = 1; hs_cnt = 0;
        vcyc = 0; timeout = 1; phase = 0; line = '0;
        req_valid = 1'b1;
        req_addr  = a;
        for (int c = 0; c < 100; c++) begin
            hs = mem_valid && mem_ready;
            if (hs) hs_cnt++;
            step;
            lat++;
            mem_rvalid = 1'b0;
            if (resp_ready) begin
                data = resp_data;
                timeout = 0;
                break;
            end
            if (hs) begin
                mem_ready  = 1'b0;
                phase      = 1;
                line       = mem_line(maddr);
                mem_rvalid = 1'b1;
                mem_rdata  = line[63:0];
            end else if (phase == 1) begin
                phase      = 2;
                mem_rvalid = 1'b1;
                mem_rdata  = line[127:64];
            end else if (mem_valid) begin
                if (!missed) begin
                    missed = 1;
                    maddr  = mem_addr;
                end
                if (mem_addr !== maddr) stable = 0;
                vcyc++;
                mem_ready = (vcyc > delay);
            end
        end
        req_valid = 1'b0;
        mem_ready = 1'b0;
        mem_rvalid = 1'b0;
        step;
        after = resp_ready;
    endtask

    task automatic do_fence(output int first, output int pulses);
        first = -1;
        pulses = 0;
        fence = 1'b1;
        step;
        fence = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            step;
            if (fence_done) begin
                pulses++;
                if (first < 0) first = c;
            end
        end
    endtask

    task automatic test_reset;
        int n;
        mem[28'h8000000] = LINE0;
        model_flush();
        rst = 1'b1;
        repeat (3) step;
        tests++;
        if ({resp_ready, abort_done, fence_done, mem_valid} !== 4'b0) begin
            fails++;
            $display("FAIL reset_ctrl got %b want 0000", {resp_ready, abort_done, fence_done, mem_valid});
        end
        tests++;
        if (resp_data !== 128'h0 || mem_addr !== 32'h0) begin
            fails++;
            $display("FAIL reset_data got data=%h addr=%h want 0", resp_data, mem_addr);
        end
        rst = 1'b0;
        n = 0;
        while (!abort_done && n < 200) begin
            step;
            n++;
        end
        tests++;
        if (n !== 64) begin
            fails++;
            $display("FAIL init_sweep got %0d cycles want 64", n);
        end
    endtask

    task automatic test_miss_fill;
        logic [127:0] d; bit m, st, to; int lat, hs, vc; logic [31:0] ma; logic af;
        fetch(32'h8000_0000, 0, d, m, lat, ma, st, hs, vc, to, af);
        tests++;
        if (to !== 0 || m !== 1 || ma !== 32'h8000_0000) begin
            fails++;
            $display("FAIL miss_req got to=%0d miss=%0d addr=%h want 0 1 80000000", to, m, ma);
        end
        tests++;
        if (d !== LINE0) begin
            fails++;
            $display("FAIL miss_data got %h want %h", d, LINE0);
        end
        tests++;
        if (af !== 1'b0) begin
            fails++;
            $display("FAIL resp_drop got %b want 0", af);
        end
        model_fill(32'h8000_0000);
    endtask

    task automatic test_hit;
        logic [127:0] d; bit m, st, to; int lat, hs, vc; logic [31:0] ma; logic af;
        fetch(32'h8000_0008, 0, d, m, lat, ma, st, hs, vc, to, af);
        tests++;
        if (to !== 0 || m !== 0 || lat !== 2) begin
            fails++;
            $display("FAIL hit_lat got to=%0d miss=%0d lat=%0d want 0 0 2", to, m, lat);
        end
        tests++;
        if (d !== LINE0) begin
            fails++;
            $display("FAIL hit_data got %h want %h", d, LINE0);
        end
    endtask

    task automatic test_replace;
        logic [127:0] d; bit m, st, to; int lat, hs, vc; logic [31:0] ma; logic af;
        fetch(32'h8000_0400, 1, d, m, lat, ma, st, hs, vc, to, af);
        tests++;
        if (to !== 0 || m !== 1 || ma !== 32'h8000_0400 || d !== mem_line(32'h8000_0400)) begin
            fails++;
            $display("FAIL replace_fill got miss=%0d addr=%h data=%h", m, ma, d);
        end
        model_fill(32'h8000_0400);
        fetch(32'h8000_0000, 0, d, m, lat, ma, st, hs, vc, to, af);
        tests++;
        if (to !== 0 || m !== 1 || d !== LINE0) begin
            fails++;
            $display("FAIL replace_evict got miss=%0d data=%h want 1 %h", m, d, LINE0);
        end
        model_fill(32'h8000_0000);
    endtask

    task automatic test_abort;
        logic [127:0] line, d; bit m, st, to, rose, early; int n, lat, hs, vc; logic [31:0] ma; logic af;
        logic [31:0] a;
        for (int k = 0; k < 2; k++) begin
            a = (k == 0) ? 32'h8000_1230 : 32'h8000_1240;
            line = mem_line(a);
            req_valid = 1'b1;
            req_addr  = a;
            n = 0;
            while (!mem_valid && n < 20) begin
                step;
                n++;
            end
            tests++;
            if (mem_valid !== 1'b1 || mem_addr !== {a[31:4], 4'b0}) begin
                fails++;
                $display("FAIL abort_req%0d got valid=%b addr=%h", k, mem_valid, mem_addr);
            end
            mem_ready = 1'b1;
            step;
            mem_ready = 1'b0;
            mem_rvalid = 1'b1;
            mem_rdata = line[63:0];
            step;
            rose = 0;
            early = 0;
            if (k == 0) begin
                mem_rvalid = 1'b0;
                abort = 1'b1;
                req_valid = 1'b0;
                step;
                abort = 1'b0;
                rose = resp_ready;
                early = abort_done;
                repeat (3) begin
                    step;
                    rose |= resp_ready;
                    early |= abort_done;
                end
                mem_rvalid = 1'b1;
                mem_rdata = line[127:64];
                step;
            end else begin
                mem_rdata = line[127:64];
                abort = 1'b1;
                req_valid = 1'b0;
                step;
                abort = 1'b0;
            end
            mem_rvalid = 1'b0;
            rose |= resp_ready;
            tests++;
            if (early !== 0 || abort_done !== 1'b1 || rose !== 0) begin
                fails++;
                $display("FAIL abort_drain%0d got early=%0d done=%b resp=%0d want 0 1 0", k, early, abort_done, rose);
            end
            model_fill(a);
            step;
            fetch(a, 0, d, m, lat, ma, st, hs, vc, to, af);
            tests++;
            if (to !== 0 || m !== 0 || d !== line) begin
                fails++;
                $display("FAIL abort_kept%0d got miss=%0d data=%h want 0 %h", k, m, d, line);
            end
        end
    endtask

    task automatic test_fence;
        logic [127:0] d; bit m, st, to; int lat, hs, vc, first, pulses; logic [31:0] ma; logic af;
        do_fence(first, pulses);
        model_flush();
        tests++;
        if (first !== 64 || pulses !== 1) begin
            fails++;
            $display("FAIL fence_pulse got first=%0d pulses=%0d want 64 1", first, pulses);
        end
        fetch(32'h8000_0000, 0, d, m, lat, ma, st, hs, vc, to, af);
        tests++;
        if (to !== 0 || m !== 1 || d !== LINE0) begin
            fails++;
            $display("FAIL fence_miss got miss=%0d data=%h want 1 %h", m, d, LINE0);
        end
        model_fill(32'h8000_0000);
    endtask

    task automatic test_mem_stall;
        logic [127:0] d; bit m, st, to; int lat, hs, vc; logic [31:0] ma; logic af;
        fetch(32'h8000_2000, 5, d, m, lat, ma, st, hs, vc, to, af);
        tests++;
        if (to !== 0 || st !== 1 || ma !== 32'h8000_2000 || vc !== 6) begin
            fails++;
            $display("FAIL stall_hold got stable=%0d addr=%h valid_cycles=%0d want 1 80002000 6", st, ma, vc);
        end
        tests++;
        if (hs !== 1 || d !== mem_line(32'h8000_2000)) begin
            fails++;
            $display("FAIL stall_once got handshakes=%0d data=%h", hs, d);
        end
        model_fill(32'h8000_2000);
    endtask

    task automatic test_random;
        logic [127:0] d; bit m, st, to, exp_hit; int lat, hs, vc, first, pulses; logic [31:0] ma, a; logic af;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                do_fence(first, pulses);
                model_flush();
                tests++;
                if (first !== 64 || pulses !== 1) begin
                    fails++;
                    $display("FAIL rnd_fence%0d got first=%0d pulses=%0d", i, first, pulses);
                end
            end
            a = 32'h8000_0000 | ($urandom_range(0, 2) << 10) | ($urandom_range(0, 3) << 4) | $urandom_range(0, 15);
            exp_hit = model_hit(a);
            fetch(a, $urandom_range(0, 3), d, m, lat, ma, st, hs, vc, to, af);
            tests++;
            if (to !== 0 || m !== !exp_hit || d !== mem_line(a) || (exp_hit && lat !== 2) || (!exp_hit && hs !== 1)) begin
                fails++;
                $display("FAIL rnd%0d addr=%h got miss=%0d lat=%0d data=%h want miss=%0d data=%h",
                         i, a, m, lat, d, !exp_hit, mem_line(a));
            end
            model_fill(a);
        end
    endtask

    initial begin
        test_reset();
        test_miss_fill();
        test_hit();
        test_replace();
        test_abort();
        test_fence();
        test_mem_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
